// File: rtl/quad_filter.sv
// Quadrature encoder front end: per-channel synchronizer and debouncer, then a step/direction decoder.
// Optional macro QUAD_FILTER_ERR_CNT_EN adds the saturating illegal-transition counter on err_cnt.
module quad_filter #(
  parameter int COUNTER_WIDTH = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  output logic       cnt,
  output logic       dir,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int SETTLE_WIDTH = COUNTER_WIDTH + 1;

  // Channel vectors are packed as {a, b} throughout.
  logic [1:0]                      sync1_q, sync1_d;
  logic [1:0]                      sync2_q, sync2_d;
  logic [1:0]                      deb_q, deb_d;
  logic [1:0][COUNTER_WIDTH-1:0]   win_q, win_d;
  logic [1:0]                      prev_q, prev_d;
  logic [SETTLE_WIDTH-1:0]         settle_q, settle_d;
  logic                            settled_q, settled_d;
  logic                            cnt_q, cnt_d;
  logic                            dir_q, dir_d;
  logic                            err_q, err_d;

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
    sync1_d   = {a, b};
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    win_d     = win_q;
    settle_d  = settle_q;
    settled_d = settled_q;
    prev_d    = deb_q;
    cnt_d     = 1'b0;
    err_d     = 1'b0;
    dir_d     = dir_q;

    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        win_d[i] = '0;
      end else if (win_q[i] != '1) begin
        win_d[i] = win_q[i] + COUNTER_WIDTH'(1);
      end else begin
        deb_d[i] = sync2_q[i];
        win_d[i] = '0;
      end
    end

    // Startup settle: lets the debouncers catch up with idle pins before decoding.
    if (!settled_q) begin
      if (settle_q == '1) settled_d = 1'b1;
      else                settle_d  = settle_q + SETTLE_WIDTH'(1);
    end

    if (settled_q && (deb_q != prev_q)) begin
      case ({prev_q, deb_q})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
          cnt_d = 1'b1;
          dir_d = 1'b1;
        end
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
          cnt_d = 1'b1;
          dir_d = 1'b0;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      win_q     <= '0;
      prev_q    <= '0;
      settle_q  <= '0;
      settled_q <= 1'b0;
      cnt_q     <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      win_q     <= win_d;
      prev_q    <= prev_d;
      settle_q  <= settle_d;
      settled_q <= settled_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
    end
  end

  assign cnt = cnt_q;
  assign dir = dir_q;
  assign err = err_q;

`ifdef QUAD_FILTER_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'h00;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: doc/quad_filter.md
QUAD_FILTER -- requirements
Module: quad_filter

Interface
REQ-001 Parameter COUNTER_WIDTH, default 11, sets the debounce window width; the window is 2^COUNTER_WIDTH clk cycles.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  1  raw encoder channel A, asynchronous to clk.
REQ-005 b  input  1  raw encoder channel B, asynchronous to clk.
REQ-006 cnt  output  1  one-cycle pulse, one per legal quadrature step.
REQ-007 dir  output  1  direction of the last step: 1 = forward, 0 = reverse; valid while cnt=1, held otherwise.
REQ-008 err  output  1  one-cycle pulse on an illegal quadrature transition.
REQ-009 err_cnt  output  8  saturating count of illegal transitions.

Function
REQ-010 Each of a and b SHALL pass through a 2-flop synchronizer; sa/sb is the second-stage value.
REQ-011 Each channel SHALL have a debouncer with state da/db and a COUNTER_WIDTH-bit counter.
REQ-012 Debouncer, when synced == debounced: the counter clears to 0.
REQ-013 Debouncer, when synced != debounced and counter < all-ones: the counter increments.
REQ-014 Debouncer, when synced != debounced and counter == all-ones: debounced takes the synced value and the counter clears; a change therefore needs 2^COUNTER_WIDTH consecutive differing cycles.
REQ-015 A glitch shorter than 2^COUNTER_WIDTH cycles SHALL NOT change da/db.
REQ-016 The decoder SHALL register prev = {da,db} every cycle and compare it with the current {da,db}.
REQ-017 Forward sequence {a,b}: 00->10->11->01->00; any such single-bit step SHALL pulse cnt=1 with dir=1.
REQ-018 Reverse sequence {a,b}: 00->01->11->10->00; any such single-bit step SHALL pulse cnt=1 with dir=0.
REQ-019 When both bits change in the same cycle, the decoder SHALL pulse err=1, leave cnt=0 and dir unchanged, and increment err_cnt, which saturates at 8'hFF.
REQ-020 cnt, dir and err SHALL be registered and appear exactly 1 cycle after the cycle in which da/db change.
REQ-021 Total latency from a clean pin edge to cnt is 2 synchronizer cycles + 2^COUNTER_WIDTH debounce cycles + 1 decoder cycle.
REQ-022 cnt and err SHALL never be 1 in the same cycle.
REQ-023 An unchanged {da,db} SHALL produce no pulse.
REQ-024 Settle window: after reset release, a (COUNTER_WIDTH+1)-bit settle counter SHALL run for 2^(COUNTER_WIDTH+1) cycles.
REQ-025 During the settle window, prev SHALL track {da,db}, cnt and err SHALL be forced 0, and err_cnt SHALL NOT increment.
REQ-026 Without the settle window rule, pins idling at 11 would produce a spurious err at startup; the settle window prevents this.

Reset
REQ-027 rst_n=0 SHALL immediately clear the synchronizers, da, db, the debounce counters, prev, the settle counter, cnt, dir, err and err_cnt to 0, including mid-step or mid-debounce.
REQ-028 After release, REQ-024 and REQ-025 apply before any cnt or err can be produced.

Configuration
REQ-029 Macro QUAD_FILTER_ERR_CNT_EN: when defined, err_cnt and its saturating counter are implemented per REQ-019.
REQ-030 When QUAD_FILTER_ERR_CNT_EN is undefined, err_cnt SHALL be tied to 8'h00 with no counter flops; err, cnt and dir are unaffected.

Verification (COUNTER_WIDTH=3, window 8, settle 16)
REQ-031 Reset with a=b=1 held, then release -> no cnt and no err ever; after settle, prev=11.
REQ-032 After settle, drive the full forward sequence 00->10->11->01->00, each level held 20 cycles -> exactly 4 cnt pulses, each with dir=1, each 11 cycles after its pin edge.
REQ-033 Drive the full reverse sequence 00->01->11->10->00 -> exactly 4 cnt pulses, each with dir=0.
REQ-034 Toggle a for 5 cycles, then return it -> da unchanged, no cnt, no err.
REQ-035 Change a and b in the same cycle from 00 to 11 -> one err pulse, cnt=0, err_cnt=1; after 300 such events err_cnt=255 and holds.
REQ-036 Assert rst_n=0 mid-debounce, 4 cycles into a change -> all outputs 0 at once; after release, no pulse until settle completes and then a full window elapses.
